// File: rtl/memory_types_pkg.sv
// memory_types_pkg: packet type, len encodings and byte-lane helpers shared by the memory port
package memory_types_pkg;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} mem_type_e;
    typedef struct packed {
        mem_type_e   mtype;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_pkt_t;
    localparam logic [1:0] MEM_LEN_WORD = 2'd0;
    localparam logic [1:0] MEM_LEN_BYTE = 2'd1;
    localparam logic [1:0] MEM_LEN_HALF = 2'd2;
    function automatic logic [3:0] mem_byte_en(input logic [1:0] len, input logic [1:0] ofs);
        return len == MEM_LEN_BYTE ? 4'b0001 << ofs :
               len == MEM_LEN_HALF ? (ofs[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
    // replicating the low lanes lets the byte enables pick the target lane
    function automatic logic [31:0] mem_wr_lanes(input logic [1:0] len, input logic [31:0] data);
        return len == MEM_LEN_BYTE ? {4{data[7:0]}} : len == MEM_LEN_HALF ? {2{data[15:0]}} : data;
    endfunction
    function automatic logic [31:0] mem_rd_align(input logic [1:0] len, input logic [1:0] ofs, input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {ofs, 3'b000};
        return len == MEM_LEN_BYTE ? {24'd0, sh[7:0]} :
               len == MEM_LEN_HALF ? {16'd0, ofs[1] ? word[31:16] : word[15:0]} : word;
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: valid/ready request and response channels of the memory port
interface mem_responder_if;
    import memory_types_pkg::*;
    logic req_vld, req_rdy, rsp_vld, rsp_rdy;
    mem_pkt_t req, rsp;
    modport master(output req_vld, req, rsp_rdy, input req_rdy, rsp_vld, rsp);
    modport slave(input req_vld, req, rsp_rdy, output req_rdy, rsp_vld, rsp);
endinterface

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo: circular response queue with combinational head; push and pop may share an edge when full
module mem_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter type T = memory_types_pkg::mem_pkt_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    T buffer [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head = empty ? T'('0) : buffer[rptr];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= bump(wptr);
            if (do_pop) rptr <= bump(rptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) buffer[wptr] <= push_data;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: in-order read/write responder on a word array with a credit-limited response FIFO
// Define MEM_RESPONDER_STALL_EN to add LFSR-driven request stalls
module mem_responder
    import memory_types_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY = 1,
    parameter int RSP_DEPTH = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic clk,
    input logic rst,
    mem_responder_if.slave port
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int OW = $clog2(RSP_DEPTH + 1);
    logic [31:0] mem [MEM_WORDS];
    logic [OW-1:0] outst;
    logic accept, xfer, stall, fifo_full, fifo_empty, unused;
    logic [AW-1:0] widx;
    logic [1:0] ofs;
    logic [3:0] be;
    logic [31:0] wdata;
    mem_pkt_t rsp_pkt;
    logic pv [LATENCY];
    mem_pkt_t pp [LATENCY];
    // credit returned by a same-cycle response transfer keeps one accept per cycle
    assign xfer = port.rsp_vld && port.rsp_rdy;
    assign port.req_rdy = !rst && (outst < OW'(RSP_DEPTH) || xfer) && !stall;
    assign accept = port.req_vld && port.req_rdy;
    assign port.rsp_vld = !fifo_empty;
    assign widx = port.req.addr[AW+1:2];
    assign ofs = port.req.addr[1:0];
    assign be = mem_byte_en(port.req.len, ofs);
    assign wdata = mem_wr_lanes(port.req.len, port.req.data);
    always_comb begin
        rsp_pkt = port.req;
        rsp_pkt.data = port.req.mtype == WRITE ? '0 : mem_rd_align(port.req.len, ofs, mem[widx]);
    end
    always_ff @(posedge clk)
        if (accept && port.req.mtype == WRITE)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    always_ff @(posedge clk or posedge rst)
        if (rst) outst <= '0;
        else if (accept != xfer) outst <= accept ? outst + 1'b1 : outst - 1'b1;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pv[i] <= pv[i-1];
        end
    always_ff @(posedge clk) begin
        pp[0] <= rsp_pkt;
        for (int i = 1; i < LATENCY; i++) pp[i] <= pp[i-1];
    end
    mem_rsp_fifo #(.DEPTH(RSP_DEPTH), .T(mem_pkt_t)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(pv[LATENCY-1]),
        .push_data(pp[LATENCY-1]),
        .pop(xfer),
        .head(port.rsp),
        .full(fifo_full),
        .empty(fifo_empty)
    );
`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge rst)
        if (rst) lfsr <= LFSR_SEED;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign stall = lfsr[1:0] == 2'b00;
    assign unused = fifo_full;
`else
    assign stall = 1'b0;
    assign unused = ^{fifo_full, LFSR_SEED};
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of the memory responder plus a scoreboarded random run
module tb_mem_responder;
    import memory_types_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    int tests = 0, fails = 0, cyc = 0, acc = 0;
    mem_pkt_t rq[$];
    int rt[$], at[$];
    mem_responder_if bus();
    mem_responder dut(.clk(clk), .rst(rst), .port(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus.req_vld && bus.req_rdy) begin acc++; at.push_back(cyc); end
        if (bus.rsp_vld && bus.rsp_rdy) begin rq.push_back(bus.rsp); rt.push_back(cyc); end
    end
    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic mem_pkt_t pk(input mem_type_e t, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
        pk.mtype = t; pk.addr = a; pk.len = l; pk.data = d;
    endfunction

    task automatic clear();
        rq.delete(); rt.delete(); at.delete();
    endtask

    task automatic send(input mem_pkt_t p);
        int n = 0;
        bus.req = p;
        bus.req_vld = 1'b1;
        @(negedge clk);
        while (!bus.req_rdy && n < 50) begin @(negedge clk); n++; end
        if (n == 50) begin
            fails++;
            $display("FAIL send_timeout addr %h got no req_rdy, want req_rdy within 50 cycles", p.addr);
        end
        @(posedge clk); #1;
        bus.req_vld = 1'b0;
    endtask

    task automatic wait_rsp(input int k);
        int n = 0;
        while (rq.size() < k && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset();
        bus.req_vld = 1'b0; bus.rsp_rdy = 1'b0; bus.req = '0; rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (bus.req_rdy !== 1'b0) begin fails++; $display("FAIL reset_req_rdy got %b want 0", bus.req_rdy); end
        tests++; if (bus.rsp_vld !== 1'b0) begin fails++; $display("FAIL reset_rsp_vld got %b want 0", bus.rsp_vld); end
        tests++; if (bus.rsp !== '0) begin fails++; $display("FAIL reset_rsp got %h want 0", bus.rsp); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.req_rdy !== 1'b1) begin fails++; $display("FAIL post_reset_req_rdy got %b want 1", bus.req_rdy); end
        tests++; if (dut.outst !== '0) begin fails++; $display("FAIL post_reset_outst got %0d want 0", dut.outst); end
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        mem_pkt_t exp [6];
        exp[0] = pk(WRITE, 32'h40, MEM_LEN_WORD, 32'h0);
        exp[1] = pk(READ, 32'h40, MEM_LEN_WORD, 32'hDEADBEEF);
        exp[2] = pk(READ, 32'h41, MEM_LEN_BYTE, 32'h000000BE);
        exp[3] = pk(READ, 32'h42, MEM_LEN_HALF, 32'h0000DEAD);
        exp[4] = pk(READ, 32'h43, 2'd3, 32'hDEADBEEF);
        exp[5] = pk(READ, 32'h1040, MEM_LEN_WORD, 32'hDEADBEEF);
        clear();
        bus.rsp_rdy = 1'b1;
        send(pk(WRITE, 32'h40, MEM_LEN_WORD, 32'hDEADBEEF));
        send(pk(READ, 32'h40, MEM_LEN_WORD, 32'h0));
        send(pk(READ, 32'h41, MEM_LEN_BYTE, 32'hFFFFFFFF));
        send(pk(READ, 32'h42, MEM_LEN_HALF, 32'h0));
        send(pk(READ, 32'h43, 2'd3, 32'h0));
        send(pk(READ, 32'h1040, MEM_LEN_WORD, 32'h0));
        wait_rsp(6);
        tests++; if (rq.size() !== 6) begin fails++; $display("FAIL read_count got %0d want 6", rq.size()); end
        for (int i = 0; i < 6 && i < rq.size(); i++) begin
            tests++;
            if (rq[i] !== exp[i]) begin fails++; $display("FAIL read_rsp%0d got %h want %h", i, rq[i], exp[i]); end
        end
        tests++; if (rt[1] - at[1] !== 2) begin fails++; $display("FAIL read_latency got %0d want 2", rt[1] - at[1]); end
        @(negedge clk);
        tests++; if (bus.rsp_vld !== 1'b0 || bus.rsp !== '0) begin fails++; $display("FAIL idle_rsp got vld %b pkt %h want 0 0", bus.rsp_vld, bus.rsp); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_word_write();
        clear();
        bus.rsp_rdy = 1'b1;
        send(pk(WRITE, 32'h40, MEM_LEN_WORD, 32'h0));
        send(pk(WRITE, 32'h43, MEM_LEN_BYTE, 32'h123456AA));
        send(pk(READ, 32'h40, MEM_LEN_WORD, 32'h0));
        send(pk(READ, 32'h42, MEM_LEN_HALF, 32'h0));
        send(pk(WRITE, 32'h44, MEM_LEN_WORD, 32'h11223344));
        send(pk(WRITE, 32'h47, MEM_LEN_HALF, 32'hFFFF1234));
        send(pk(READ, 32'h44, MEM_LEN_WORD, 32'h0));
        wait_rsp(7);
        tests++; if (rq.size() !== 7) begin fails++; $display("FAIL sub_count got %0d want 7", rq.size()); end
        tests++; if (rq[1] !== pk(WRITE, 32'h43, MEM_LEN_BYTE, 32'h0)) begin fails++; $display("FAIL wr_rsp got %h want %h", rq[1], pk(WRITE, 32'h43, MEM_LEN_BYTE, 32'h0)); end
        tests++; if (at[2] - at[1] !== 1) begin fails++; $display("FAIL raw_gap got %0d want 1", at[2] - at[1]); end
        tests++; if (rq[2].data !== 32'hAA000000) begin fails++; $display("FAIL byte_raw got %h want aa000000", rq[2].data); end
        tests++; if (rq[3].data !== 32'h0000AA00) begin fails++; $display("FAIL half_rd got %h want 0000aa00", rq[3].data); end
        tests++; if (rq[6].data !== 32'h12343344) begin fails++; $display("FAIL half_wr got %h want 12343344", rq[6].data); end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        clear();
        bus.rsp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(pk(WRITE, 32'(4 * i), MEM_LEN_WORD, 32'h1000 + 32'(i)));
        for (int i = 0; i < 8; i++) send(pk(READ, 32'(4 * i), MEM_LEN_WORD, 32'h0));
        wait_rsp(16);
        tests++; if (rq.size() !== 16) begin fails++; $display("FAIL b2b_count got %0d want 16", rq.size()); end
        for (int i = 9; i < 16 && i < at.size(); i++) if (at[i] - at[i-1] != 1) gaps++;
        tests++; if (gaps !== 0) begin fails++; $display("FAIL b2b_gaps got %0d want 0", gaps); end
        for (int i = 0; i < 8 && 8 + i < rq.size(); i++) begin
            tests++;
            if (rq[8+i] !== pk(READ, 32'(4 * i), MEM_LEN_WORD, 32'h1000 + 32'(i))) begin
                fails++; $display("FAIL b2b_rsp%0d got %h want %h", i, rq[8+i], pk(READ, 32'(4 * i), MEM_LEN_WORD, 32'h1000 + 32'(i)));
            end
        end
    endtask

    task automatic test_backpressure();
        int a0 = acc;
        clear();
        bus.rsp_rdy = 1'b0;
        bus.req_vld = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.req = pk(READ, 32'(4 * (acc - a0)), MEM_LEN_WORD, 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests++; if (acc - a0 !== 2) begin fails++; $display("FAIL bp_accepts got %0d want 2", acc - a0); end
        tests++; if (bus.req_rdy !== 1'b0) begin fails++; $display("FAIL bp_req_rdy got %b want 0", bus.req_rdy); end
        tests++; if (bus.rsp_vld !== 1'b1 || bus.rsp !== pk(READ, 32'h0, MEM_LEN_WORD, 32'h1000)) begin
            fails++; $display("FAIL bp_head got vld %b pkt %h want 1 %h", bus.rsp_vld, bus.rsp, pk(READ, 32'h0, MEM_LEN_WORD, 32'h1000));
        end
        @(posedge clk); #1;
        bus.rsp_rdy = 1'b1;
        @(negedge clk);
        tests++; if (bus.req_rdy !== 1'b1) begin fails++; $display("FAIL credit_return got %b want 1", bus.req_rdy); end
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            bus.req = pk(READ, 32'(4 * (acc - a0)), MEM_LEN_WORD, 32'h0);
            @(posedge clk); #1;
        end
        bus.req_vld = 1'b0;
        tests++; if (acc - a0 !== 8) begin fails++; $display("FAIL bp_resume got %0d want 8", acc - a0); end
        wait_rsp(8);
        tests++; if (rq.size() !== 8) begin fails++; $display("FAIL bp_count got %0d want 8", rq.size()); end
        for (int i = 0; i < 8 && i < rq.size(); i++) begin
            tests++;
            if (rq[i] !== pk(READ, 32'(4 * i), MEM_LEN_WORD, 32'h1000 + 32'(i))) begin
                fails++; $display("FAIL bp_order%0d got %h want %h", i, rq[i], pk(READ, 32'(4 * i), MEM_LEN_WORD, 32'h1000 + 32'(i)));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear();
        bus.rsp_rdy = 1'b0;
        send(pk(WRITE, 32'h20, MEM_LEN_WORD, 32'h5A5A5A5A));
        send(pk(READ, 32'h0, MEM_LEN_WORD, 32'h0));
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        tests++; if (bus.rsp_vld !== 1'b1) begin fails++; $display("FAIL mid_queued got %b want 1", bus.rsp_vld); end
        tests++; if (dut.outst !== 2) begin fails++; $display("FAIL mid_outst got %0d want 2", dut.outst); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++; if (bus.rsp_vld !== 1'b0) begin fails++; $display("FAIL mid_rst_vld got %b want 0", bus.rsp_vld); end
        tests++; if (bus.req_rdy !== 1'b0) begin fails++; $display("FAIL mid_rst_rdy got %b want 0", bus.req_rdy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (dut.outst !== '0) begin fails++; $display("FAIL mid_outst_clr got %0d want 0", dut.outst); end
        tests++; if (bus.req_rdy !== 1'b1) begin fails++; $display("FAIL mid_req_rdy got %b want 1", bus.req_rdy); end
        @(posedge clk); #1;
        bus.rsp_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tests++; if (rq.size() !== 0) begin fails++; $display("FAIL stale_rsp got %0d want 0", rq.size()); end
        send(pk(READ, 32'h20, MEM_LEN_WORD, 32'h0));
        send(pk(READ, 32'h0, MEM_LEN_WORD, 32'h0));
        wait_rsp(2);
        tests++; if (rq.size() !== 2) begin fails++; $display("FAIL mid_count got %0d want 2", rq.size()); end
        tests++; if (rq[0].data !== 32'h5A5A5A5A) begin fails++; $display("FAIL kept_write got %h want 5a5a5a5a", rq[0].data); end
        tests++; if (rq[1].data !== 32'h1000) begin fails++; $display("FAIL kept_word got %h want 00001000", rq[1].data); end
    endtask

    task automatic test_random();
        logic [31:0] m [16];
        mem_pkt_t eq[$];
        mem_pkt_t p, e;
        int issued = 0, errs = 0, w, o;
        logic hit;
        clear();
        bus.rsp_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m[i] = $urandom;
            send(pk(WRITE, 32'(4 * i), MEM_LEN_WORD, m[i]));
        end
        wait_rsp(16);
        clear();
        for (int c = 0; c < 20000 && issued < 1000; c++) begin
            bus.rsp_rdy = $urandom_range(0, 3) != 0;
            if (!bus.req_vld && $urandom_range(0, 3) != 0) begin
                p.mtype = $urandom_range(0, 1) != 0 ? WRITE : READ;
                p.addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
                p.len = 2'($urandom_range(0, 3));
                p.data = $urandom;
                bus.req = p;
                bus.req_vld = 1'b1;
            end
            @(negedge clk);
            hit = bus.req_vld && bus.req_rdy;
            if (hit) begin
                p = bus.req;
                w = int'(p.addr[5:2]);
                o = int'(p.addr[1:0]);
                e = p;
                if (p.mtype == WRITE) begin
                    e.data = 32'h0;
                    if (p.len == 2'd1) m[w][8*o +: 8] = p.data[7:0];
                    else if (p.len == 2'd2) m[w][16*(o/2) +: 16] = p.data[15:0];
                    else m[w] = p.data;
                end else
                    e.data = p.len == 2'd1 ? (m[w] >> (8 * o)) & 32'hFF :
                             p.len == 2'd2 ? (m[w] >> (16 * (o / 2))) & 32'hFFFF : m[w];
                eq.push_back(e);
                issued++;
            end
            @(posedge clk); #1;
            if (hit) bus.req_vld = 1'b0;
        end
        bus.req_vld = 1'b0;
        bus.rsp_rdy = 1'b1;
        wait_rsp(issued);
        tests++; if (issued !== 1000) begin fails++; $display("FAIL rand_issued got %0d want 1000", issued); end
        tests++; if (rq.size() !== eq.size()) begin fails++; $display("FAIL rand_count got %0d want %0d", rq.size(), eq.size()); end
        for (int i = 0; i < eq.size(); i++)
            if (i >= rq.size() || rq[i] !== eq[i]) begin
                if (errs == 0 && i < rq.size()) $display("FAIL rand_rsp%0d got %h want %h", i, rq[i], eq[i]);
                errs++;
            end
        tests++; if (errs !== 0) begin fails++; $display("FAIL rand_mismatches got %0d want 0", errs); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_sub_word_write();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
